// File: rtl/grn_result_arbiter.sv
// Round-robin collector: grants one finished grn engine at a time and packs 8 records per 512-bit line.
// Define GRN_ARB_STATS_EN to add saturating stat_records / stat_lines counters.
module grn_result_arbiter #(
  parameter int BLOCKS_NUMBER = 16,
  parameter int VECTOR_SIZE   = 69,
  parameter int LINE_RECORDS  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BLOCKS_NUMBER-1:0]           done_in,
  input  logic [BLOCKS_NUMBER*32-1:0]        transient_in,
  input  logic [BLOCKS_NUMBER*VECTOR_SIZE-1:0] conf_in,
  output logic [BLOCKS_NUMBER-1:0]           grant_out,
  input  logic                               flush_in,
  output logic                               req_write,
  input  logic                               ack_write,
  output logic [511:0]                       line_out,
  output logic [4:0]                         words_out,
  output logic                               flush_done,
  output logic                               busy
`ifdef GRN_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_records,
  output logic [31:0]                        stat_lines
`endif
);

  localparam int PTR_W  = (BLOCKS_NUMBER > 1) ? $clog2(BLOCKS_NUMBER) : 1;
  localparam int SLOT_W = $clog2(LINE_RECORDS);
  localparam logic [BLOCKS_NUMBER-1:0] ONE_B = {{(BLOCKS_NUMBER-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_ARB, S_GAP, S_WRITE, S_FWRITE} state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic                     flush_pend_q, flush_pend_d;
  logic [BLOCKS_NUMBER-1:0] grant_q, grant_d;
  logic                     req_q, req_d;
  logic [511:0]             line_q, line_d;
  logic [4:0]               words_q, words_d;
  logic                     flush_done_q, flush_done_d;

  logic [BLOCKS_NUMBER-1:0] hi_mask, masked, pick_src, win_oh;
  logic [PTR_W-1:0]         win_idx;
  logic [31:0]              win_tr, win_cf;
  logic                     unused_conf;

  // Only conf[31:0] of each engine is packed.
  assign unused_conf = ^conf_in;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_mask  = ~((ONE_B << rr_ptr_q) - ONE_B);
    masked   = done_in & hi_mask;
    pick_src = (|masked) ? masked : done_in;
    win_oh   = pick_src & (~pick_src + ONE_B);
    win_idx  = '0;
    win_tr   = '0;
    win_cf   = '0;
    for (int i = 0; i < BLOCKS_NUMBER; i++) begin
      if (win_oh[i]) begin
        win_idx = PTR_W'(i);
        win_tr  = transient_in[i*32 +: 32];
        win_cf  = conf_in[i*VECTOR_SIZE +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    slot_d       = slot_q;
    flush_pend_d = flush_pend_q;
    grant_d      = '0;
    req_d        = req_q;
    line_d       = line_q;
    words_d      = words_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_ARB: begin
        if (|done_in) begin
          grant_d  = win_oh;
          rr_ptr_d = (win_idx == PTR_W'(BLOCKS_NUMBER - 1)) ? '0 : win_idx + PTR_W'(1);
          slot_d   = slot_q + SLOT_W'(1);
          for (int k = 0; k < LINE_RECORDS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
              line_d[k*64 +: 32]      = win_tr;
              line_d[k*64 + 32 +: 32] = win_cf;
            end
          end
          if (slot_q == SLOT_W'(LINE_RECORDS - 1)) begin
            req_d   = 1'b1;
            words_d = 5'd16;
            state_d = S_WRITE;
          end else begin
            state_d = S_GAP;
          end
        end else if (flush_pend_q && (slot_q != '0)) begin
          req_d   = 1'b1;
          words_d = {1'b0, slot_q, 1'b0};
          state_d = S_FWRITE;
        end else if (flush_pend_q) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      S_GAP: state_d = S_ARB;
      S_WRITE, S_FWRITE: begin
        if (ack_write) begin
          req_d   = 1'b0;
          line_d  = '0;
          words_d = '0;
          slot_d  = '0;
          state_d = S_ARB;
          if (state_q == S_FWRITE) begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_ARB;
    endcase
    // A flush request arriving in any state is remembered until serviced.
    if (flush_in) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ARB;
      rr_ptr_q     <= '0;
      slot_q       <= '0;
      flush_pend_q <= 1'b0;
      grant_q      <= '0;
      req_q        <= 1'b0;
      line_q       <= '0;
      words_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      slot_q       <= slot_d;
      flush_pend_q <= flush_pend_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      line_q       <= line_d;
      words_q      <= words_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign grant_out  = grant_q;
  assign req_write  = req_q;
  assign line_out   = line_q;
  assign words_out  = words_q;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != S_ARB);

`ifdef GRN_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_records_q, stat_records_d;
  logic [31:0] stat_lines_q, stat_lines_d;

  always_comb begin
    stat_records_d = stat_records_q;
    stat_lines_d   = stat_lines_q;
    if (|grant_d) stat_records_d = sat_inc(stat_records_q);
    if (((state_q == S_WRITE) || (state_q == S_FWRITE)) && ack_write)
      stat_lines_d = sat_inc(stat_lines_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_records_q <= '0;
      stat_lines_q   <= '0;
    end else begin
      stat_records_q <= stat_records_d;
      stat_lines_q   <= stat_lines_d;
    end
  end

  assign stat_records = stat_records_q;
  assign stat_lines   = stat_lines_q;
`endif

endmodule

// File: tb/tb_grn_result_arbiter.sv
// Bench for grn_result_arbiter: round-robin vector table, scoreboarded lines, flush/backpressure/reset sequences.
module tb_grn_result_arbiter;
  localparam int B  = 16;
  localparam int VS = 69;

  logic              clk = 1'b0;
  logic              rst;
  logic [B-1:0]      done_in;
  logic [B*32-1:0]   transient_in;
  logic [B*VS-1:0]   conf_in;
  logic [B-1:0]      grant_out;
  logic              flush_in;
  logic              req_write;
  logic              ack_write;
  logic [511:0]      line_out;
  logic [4:0]        words_out;
  logic              flush_done;
  logic              busy;
`ifdef GRN_ARB_STATS_EN
  logic [31:0]       stat_records;
  logic [31:0]       stat_lines;
`endif

  logic [31:0]   tr_arr[B];
  logic [VS-1:0] cf_arr[B];

  for (genvar g = 0; g < B; g++) begin : g_flat
    assign transient_in[g*32 +: 32] = tr_arr[g];
    assign conf_in[g*VS +: VS]      = cf_arr[g];
  end

  grn_result_arbiter #(.BLOCKS_NUMBER(B), .VECTOR_SIZE(VS), .LINE_RECORDS(8)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .transient_in(transient_in), .conf_in(conf_in),
    .grant_out(grant_out), .flush_in(flush_in), .req_write(req_write), .ack_write(ack_write),
    .line_out(line_out), .words_out(words_out), .flush_done(flush_done), .busy(busy)
`ifdef GRN_ARB_STATS_EN
    , .stat_records(stat_records), .stat_lines(stat_lines)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cf;
    logic [31:0] tr;
  } rec_t;

  typedef struct {
    logic [B-1:0] done;
    int           exp_idx;
    logic [31:0]  tr;
    logic [31:0]  cf;
  } vec_t;

  rec_t sb[$];
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_grants = 0;
  int   n_lines = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int eng, input logic [31:0] tr, input logic [31:0] cf);
    for (int i = 0; i < B; i++) begin
      tr_arr[i] = (i == eng) ? tr : (32'hBAD0_0000 | 32'(i));
      cf_arr[i] = {5'h15, 32'hDEAD_BEEF, ((i == eng) ? cf : (32'h0BAD_0000 | 32'(i)))};
    end
  endtask

  task automatic wait_grant(input logic [B-1:0] exp, input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (grant_out == '0 && cyc < 6);
    chk(name, grant_out, exp);
  endtask

  task automatic push_record(input int eng, input logic [31:0] tr, input logic [31:0] cf);
    int cyc;
    set_data(eng, tr, cf);
    done_in = B'(1) << eng;
    wait_grant(B'(1) << eng, $sformatf("grant eng%0d", eng), cyc);
    sb.push_back(rec_t'{cf: cf, tr: tr});
    n_grants++;
    done_in = '0;
  endtask

  task automatic wait_req();
    int c = 0;
    while (!req_write && c < 8) begin
      tick();
      c++;
    end
  endtask

  task automatic check_line(input string name, input int exp_words);
    logic [511:0] exp = '0;
    rec_t r;
    chk({name, " req"}, req_write, 1'b1);
    chk({name, " words"}, words_out, 512'(exp_words));
    for (int k = 0; k < exp_words / 2; k++) begin
      r = (sb.size() > 0) ? sb.pop_front() : rec_t'(0);
      exp = exp | (512'(r) << (k * 64));
    end
    chk({name, " line"}, line_out, exp);
  endtask

  task automatic ack_line(input string name);
    ack_write = 1'b1;
    tick();
    ack_write = 1'b0;
    n_lines++;
    chk({name, " req after ack"}, req_write, 1'b0);
    chk({name, " line after ack"}, line_out, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [511:0] saved;
    logic stable;

    vecs[0] = '{16'h0004,  2, 32'hAAAA_0001, 32'h0000_0005};
    vecs[1] = '{16'h0003,  0, 32'h1111_0000, 32'h2222_0000};
    vecs[2] = '{16'h0003,  1, 32'h1111_0001, 32'h2222_0001};
    vecs[3] = '{16'h8001, 15, 32'h1111_000F, 32'h2222_000F};
    vecs[4] = '{16'h8001,  0, 32'h3333_0000, 32'h4444_0000};
    vecs[5] = '{16'h0101,  8, 32'h3333_0008, 32'h4444_0008};
    vecs[6] = '{16'h0300,  9, 32'h3333_0009, 32'h4444_0009};
    vecs[7] = '{16'h0300,  8, 32'h5555_0008, 32'h6666_0008};

    rst = 1'b1; done_in = '0; flush_in = 1'b0; ack_write = 1'b0;
    set_data(0, 32'h0, 32'h0);
    tick(); tick();
    chk("reset req", req_write, 1'b0);
    chk("reset grant", grant_out, '0);
    chk("reset line", line_out, '0);
    chk("reset words", words_out, '0);
    chk("reset flush_done", flush_done, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Round-robin table: rr_ptr progression from reset fills exactly one line.
    for (int v = 0; v < 8; v++) begin
      set_data(vecs[v].exp_idx, vecs[v].tr, vecs[v].cf);
      done_in = vecs[v].done;
      wait_grant(B'(1) << vecs[v].exp_idx, $sformatf("vec%0d grant", v), cyc);
      if (v == 0) chk("idle grant latency", 512'(cyc), 512'(1));
      sb.push_back(rec_t'{cf: vecs[v].cf, tr: vecs[v].tr});
      n_grants++;
      done_in = '0;
      chk($sformatf("vec%0d req", v), req_write, (v == 7));
    end
    check_line("table line", 16);
    ack_line("table");

    // Fairness from a fresh rr_ptr.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_grants = 0; n_lines = 0;
    for (int i = 0; i < B; i++) begin
      tr_arr[i] = 32'hF000_0000 | 32'(i);
      cf_arr[i] = {5'h0A, 32'hCAFE_F00D, 32'h0C00_0000 | 32'(i)};
    end
    done_in = '1;
    for (int k = 0; k < B; k++) begin
      wait_grant(B'(1) << k, $sformatf("fair grant %0d", k), cyc);
      sb.push_back(rec_t'{cf: cf_arr[k][31:0], tr: tr_arr[k]});
      n_grants++;
      done_in = done_in & ~(B'(1) << k);
      if (k == 7 || k == 15) begin
        check_line($sformatf("fair line %0d", k), 16);
        ack_line("fair");
      end else begin
        chk($sformatf("fair req %0d", k), req_write, 1'b0);
      end
    end

    // Backpressure on a full line.
    for (int k = 0; k < 8; k++) push_record(k + 3, 32'h7700_0000 + 32'(k), 32'h8800_0000 + 32'(k));
    chk("bp req rises", req_write, 1'b1);
    saved = line_out;
    set_data(0, 32'h9999_0000, 32'h9999_0001);
    done_in = 16'h0001;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!req_write || grant_out != '0 || line_out !== saved || !busy) stable = 1'b0;
    end
    chk("bp hold stable", stable, 1'b1);
    check_line("bp line", 16);
    ack_write = 1'b1;
    tick();
    ack_write = 1'b0;
    n_lines++;
    chk("bp grant at ack", grant_out, '0);
    tick();
    chk("bp grant after ack", grant_out, 16'h0001);
    sb.push_back(rec_t'{cf: 32'h9999_0001, tr: 32'h9999_0000});
    n_grants++;
    done_in = '0;

    // Partial line flush with three records.
    push_record(4, 32'hABCD_0004, 32'h1234_0004);
    push_record(6, 32'hABCD_0006, 32'h1234_0006);
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    wait_req();
    check_line("flush partial", 6);
    chk("flush partial done early", flush_done, 1'b0);
    ack_line("flush partial");
    chk("flush partial done", flush_done, 1'b1);
    tick();
    chk("flush partial done clear", flush_done, 1'b0);

    // Flush with an empty line.
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    tick();
    chk("flush empty done", flush_done, 1'b1);
    chk("flush empty no req", req_write, 1'b0);
    tick();
    chk("flush empty done clear", flush_done, 1'b0);

    // Record and flush in the same cycle: record wins, then a 2-word line.
    set_data(1, 32'h5151_0001, 32'h6161_0001);
    done_in = 16'h0002; flush_in = 1'b1;
    tick();
    chk("simul grant", grant_out, 16'h0002);
    chk("simul no flush_done", flush_done, 1'b0);
    done_in = '0; flush_in = 1'b0;
    sb.push_back(rec_t'{cf: 32'h6161_0001, tr: 32'h5151_0001});
    n_grants++;
    wait_req();
    check_line("flush simul", 2);
    ack_line("flush simul");
    chk("flush simul done", flush_done, 1'b1);

    // Asynchronous reset while a line is held.
    push_record(5, 32'hDEAD_0005, 32'hBEEF_0005);
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    wait_req();
    chk("pre-reset req", req_write, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("async rst req", req_write, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst line", line_out, '0);
    sb.delete();
    n_grants = 0; n_lines = 0;
    #2 rst = 1'b0;
    tick();
    push_record(7, 32'h0707_0707, 32'h7070_7070);
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    wait_req();
    check_line("post reset slot0", 2);
    ack_line("post reset");

`ifdef GRN_ARB_STATS_EN
    chk("stat_records", stat_records, 512'(n_grants));
    chk("stat_lines", stat_lines, 512'(n_lines));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
